// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access / write-back stage.
// Opcode map: ir[31:24] is the opcode and ir[23:16] is a sub-field, for example
// the branch condition. Any opcode that is not listed here is undefined.
package mem_wb_stage_pkg;

    localparam int unsigned RIDX_W_DEF = 3;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OP_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 8'h00;
    localparam opcode_t OP_LIL  = 8'h01;
    localparam opcode_t OP_MOV  = 8'h02;
    localparam opcode_t OP_ADD  = 8'h03;
    localparam opcode_t OP_SUB  = 8'h04;
    localparam opcode_t OP_AND  = 8'h05;
    localparam opcode_t OP_OR   = 8'h06;
    localparam opcode_t OP_XOR  = 8'h07;
    localparam opcode_t OP_ADDI = 8'h08;
    localparam opcode_t OP_SUBI = 8'h09;
    localparam opcode_t OP_ANDI = 8'h0A;
    localparam opcode_t OP_ORI  = 8'h0B;
    localparam opcode_t OP_XORI = 8'h0C;
    localparam opcode_t OP_NEG  = 8'h0D;
    localparam opcode_t OP_NOT  = 8'h0E;
    localparam opcode_t OP_SLL  = 8'h0F;
    localparam opcode_t OP_SLA  = 8'h10;
    localparam opcode_t OP_SRL  = 8'h11;
    localparam opcode_t OP_SRA  = 8'h12;
    localparam opcode_t OP_CMP  = 8'h13;
    localparam opcode_t OP_CMPI = 8'h14;
    localparam opcode_t OP_LD   = 8'h15;
    localparam opcode_t OP_ST   = 8'h16;
    localparam opcode_t OP_HLT  = 8'h17;
    localparam opcode_t OP_B    = 8'h18;
    localparam opcode_t OP_BCC  = 8'h19;
    localparam opcode_t OP_JALR = 8'h1A;
    localparam opcode_t OP_RET  = 8'h1B;
    localparam opcode_t OP_JR   = 8'h1C;
    localparam opcode_t OP_PUSH = 8'h1D;
    localparam opcode_t OP_POP  = 8'h1E;

    // Class flags. ALUW and FLAGW overlap on most ALU ops.
    // NONE is the case where every flag is clear.
    typedef struct packed {
        logic aluw;
        logic flagw;
        logic ld;
        logic st;
        logic hlt;
    } op_class_t;

endpackage

// File: rtl/mem_wb_decode.sv
// Combinational classifier: ir[31:16] -> op class flags.
// Ports: ir_hi (ir[31:16]) in, cls out.
module mem_wb_decode
    import mem_wb_stage_pkg::*;
(
    input  logic [15:0] ir_hi,
    output op_class_t   cls
);

    // The sub-field never affects the class.
    logic unused_sub;
    assign unused_sub = ^ir_hi[7:0];

    always_comb begin
        cls = '0;
        case (ir_hi[15:8])
            OP_LIL, OP_MOV: cls.aluw = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
            OP_NEG, OP_NOT, OP_SLL, OP_SLA, OP_SRL, OP_SRA: begin
                cls.aluw  = 1'b1;
                cls.flagw = 1'b1;
            end
            OP_CMP, OP_CMPI: cls.flagw = 1'b1;
            OP_LD:           cls.ld    = 1'b1;
            OP_ST:           cls.st    = 1'b1;
            OP_HLT:          cls.hlt   = 1'b1;
            default:         ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage. It performs LD/ST over a req/ack port,
// writes results to the register file, keeps the Z/S flags, counts retired
// instructions and halts on HLT.
// Ports: upstream in_valid/in_ready with ir/dr/st_data/rd_idx; the data-memory
// req/ack port; the register-file write port; the flags; halted; retired.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned RIDX_W = RIDX_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir,
    input  logic [31:0]       dr,
    input  logic [31:0]       st_data,
    input  logic [RIDX_W-1:0] rd_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [RIDX_W-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              flag_z,
    output logic              flag_s,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [RIDX_W-1:0] ld_idx_q, ld_idx_d;
    logic              rf_we_q, rf_we_d;
    logic [RIDX_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_s_q, flag_s_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    op_class_t cls;
    logic      accept;

    // The low half of ir does not matter to this stage.
    logic unused_ir_lo;
    assign unused_ir_lo = ^ir[15:0];

    mem_wb_decode u_decode (
        .ir_hi (ir[31:16]),
        .cls   (cls)
    );

    assign in_ready = (state_q == ST_IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_idx_d    = ld_idx_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        flag_z_d    = flag_z_q;
        flag_s_d    = flag_s_q;
        halted_d    = halted_q;
        retired_d   = retired_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A memory op retires on its ack cycle, not here.
                    if (!(cls.ld | cls.st)) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (cls.aluw) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_idx;
                        rf_wdata_d = dr;
                    end
                    if (cls.flagw) begin
                        flag_z_d = (dr == 32'd0);
                        flag_s_d = dr[31];
                    end
                    if (cls.ld | cls.st) begin
                        state_d     = ST_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cls.st;
                        mem_addr_d  = dr;
                        mem_wdata_d = st_data;
                        ld_idx_d    = rd_idx;
                    end
                    if (cls.hlt) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    retired_d = retired_q + CNT_W'(1);
                    if (!mem_we_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ld_idx_q;
                        rf_wdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and output registers. Reset abandons any pending memory op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_idx_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            flag_z_q    <= 1'b0;
            flag_s_q    <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_idx_q    <= ld_idx_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            flag_z_q    <= flag_z_d;
            flag_s_q    <= flag_s_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign flag_z    = flag_z_q;
    assign flag_s    = flag_s_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage. It runs directed cycle vectors and then
// randomized traffic, which is checked against a transaction-level model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [31:0] ir, dr, st_data;
    logic [2:0]  rd_idx;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flag_z, flag_s, halted;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .dr(dr), .st_data(st_data), .rd_idx(rd_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_z(flag_z), .flag_s(flag_s), .halted(halted), .retired(retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle of directed stimulus. e_rdy is sampled before the edge and
    // every other e_* field after it.
    typedef struct {
        logic rst, v; opcode_t op; logic [31:0] dr, sd; logic [2:0] rd;
        logic ack; logic [31:0] rdata;
        logic e_rdy, e_we; logic [2:0] e_wa; logic [31:0] e_wd;
        logic e_z, e_s, e_req, e_mwe; logic [31:0] e_addr, e_mwd;
        logic e_halt; logic [31:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic v, input opcode_t op, input logic [31:0] d,
        input logic [31:0] sd, input logic [2:0] rd, input logic ack,
        input logic [31:0] rdata, input logic e_rdy, input logic e_we,
        input logic [2:0] e_wa, input logic [31:0] e_wd, input logic e_z,
        input logic e_s, input logic e_req, input logic e_mwe,
        input logic [31:0] e_addr, input logic [31:0] e_mwd,
        input logic e_halt, input logic [31:0] e_ret);
        vec_t x;
        x.rst = r; x.v = v; x.op = op; x.dr = d; x.sd = sd; x.rd = rd;
        x.ack = ack; x.rdata = rdata; x.e_rdy = e_rdy; x.e_we = e_we;
        x.e_wa = e_wa; x.e_wd = e_wd; x.e_z = e_z; x.e_s = e_s;
        x.e_req = e_req; x.e_mwe = e_mwe; x.e_addr = e_addr; x.e_mwd = e_mwd;
        x.e_halt = e_halt; x.e_ret = e_ret;
        return x;
    endfunction

    // Reference model state
    typedef struct { logic is_st; logic [2:0] rd; } pend_t;
    pend_t       m_pend[$];
    logic        m_halted, m_req, m_mwe, m_we, m_z, m_s;
    logic [31:0] m_addr, m_wdata, m_wd, m_ret;
    logic [2:0]  m_wa;

    function automatic logic is_aluw(input opcode_t op);
        return op inside {OP_LIL, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_NEG,
                          OP_NOT, OP_SLL, OP_SLA, OP_SRL, OP_SRA};
    endfunction

    function automatic logic is_flagw(input opcode_t op);
        return (is_aluw(op) && !(op inside {OP_LIL, OP_MOV})) || (op inside {OP_CMP, OP_CMPI});
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_halted = 0; m_req = 0; m_mwe = 0; m_we = 0; m_z = 0; m_s = 0;
        m_addr = 0; m_wdata = 0; m_wd = 0; m_ret = 0; m_wa = 0;
    endtask

    initial begin
        opcode_t op;
        pend_t   p;
        logic    e_rdy;

        rst = 1; in_valid = 0; ir = 0; dr = 0; st_data = 0; rd_idx = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outputs", {mem_req, mem_we, rf_we, flag_z, flag_s, halted, 26'd0}, 32'd0);
        chk("rst_mem_addr", mem_addr | mem_wdata, 32'd0);
        chk("rst_rf", rf_wdata | 32'(rf_waddr), 32'd0);
        chk("rst_retired", retired, 32'd0);

        // rst v op dr sd rd ack rdata | rdy we wa wd z s req mwe addr mwd halt ret
        vecs.push_back(mk(0,1,OP_ADD ,32'd5,0,3'd3,0,0,          1,1,3'd3,32'd5,0,0,0,0,0,0,0,32'd1));
        vecs.push_back(mk(0,1,OP_SUB ,32'd0,0,3'd4,0,0,          1,1,3'd4,32'd0,1,0,0,0,0,0,0,32'd2));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 1,0,0,0,1,0,0,0,0,0,0,32'd2));
        vecs.push_back(mk(0,1,OP_LD  ,32'h40,0,3'd2,0,0,         1,0,0,0,1,0,1,0,32'h40,0,0,32'd2));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 0,0,0,0,1,0,1,0,32'h40,0,0,32'd2));
        vecs.push_back(mk(0,1,OP_ADD ,32'd9,0,3'd7,0,0,          0,0,0,0,1,0,1,0,32'h40,0,0,32'd2));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 0,0,0,0,1,0,1,0,32'h40,0,0,32'd2));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,1,32'hDEADBEEF,      0,1,3'd2,32'hDEADBEEF,1,0,0,0,0,0,0,32'd3));
        vecs.push_back(mk(0,1,OP_ST  ,32'h10,32'd7,3'd1,0,0,     1,0,0,0,1,0,1,1,32'h10,32'd7,0,32'd3));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,1,32'h55,            0,0,0,0,1,0,0,0,0,0,0,32'd4));
        vecs.push_back(mk(0,1,OP_CMPI,32'h80000000,0,3'd5,0,0,   1,0,0,0,0,1,0,0,0,0,0,32'd5));
        vecs.push_back(mk(0,1,OP_HLT ,0,0,0,0,0,                 1,0,0,0,0,1,0,0,0,0,1,32'd6));
        vecs.push_back(mk(0,1,OP_ADD ,32'd1,0,3'd1,0,0,          0,0,0,0,0,1,0,0,0,0,1,32'd6));
        vecs.push_back(mk(0,1,OP_ADD ,32'd1,0,3'd1,0,0,          0,0,0,0,0,1,0,0,0,0,1,32'd6));
        vecs.push_back(mk(1,1,OP_ADD ,32'd1,0,3'd1,0,0,          0,0,0,0,0,0,0,0,0,0,0,32'd0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 1,0,0,0,0,0,0,0,0,0,0,32'd0));
        vecs.push_back(mk(0,1,OP_LD  ,32'h20,0,3'd6,0,0,         1,0,0,0,0,0,1,0,32'h20,0,0,32'd0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 0,0,0,0,0,0,1,0,32'h20,0,0,32'd0));
        vecs.push_back(mk(1,0,OP_NOP ,0,0,0,0,0,                 0,0,0,0,0,0,0,0,0,0,0,32'd0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,1,32'h1234,          1,0,0,0,0,0,0,0,0,0,0,32'd0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,0,0,0,                 1,0,0,0,0,0,0,0,0,0,0,32'd0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].v;
            ir = {vecs[i].op, 8'h00, 16'h1234}; dr = vecs[i].dr;
            st_data = vecs[i].sd; rd_idx = vecs[i].rd;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(negedge clk);
            chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
            end
            chk($sformatf("v%0d_flags", i), {30'd0, flag_z, flag_s}, {30'd0, vecs[i].e_z, vecs[i].e_s});
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                if (vecs[i].e_mwe)
                    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            end
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
            chk($sformatf("v%0d_retired", i), retired, vecs[i].e_ret);
        end

        // Randomized traffic. Cycle 0 is forced into reset to align the model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, m_halted ? 5 : 59) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 40) <= 30) op = opcode_t'($urandom_range(0, 30));
            else op = opcode_t'($urandom_range(32, 255));
            ir = {op, 8'($urandom), 16'($urandom)};
            dr = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            st_data = $urandom;
            rd_idx = 3'($urandom);
            mem_ack = (m_pend.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            #1;
            e_rdy = !rst && !m_halted && (m_pend.size() == 0);
            chk($sformatf("r%0d_in_ready", c), 32'(in_ready), 32'(e_rdy));

            m_we = 0;
            if (rst) begin
                model_reset();
            end else if (m_pend.size() != 0) begin
                if (mem_ack) begin
                    p = m_pend.pop_front();
                    m_req = 0;
                    m_ret++;
                    if (!p.is_st) begin
                        m_we = 1; m_wa = p.rd; m_wd = mem_rdata;
                    end
                end
            end else if (!m_halted && in_valid) begin
                if (is_aluw(op)) begin
                    m_we = 1; m_wa = rd_idx; m_wd = dr;
                end
                if (is_flagw(op)) begin
                    m_z = (dr == 0); m_s = dr[31];
                end
                if (op == OP_LD || op == OP_ST) begin
                    p.is_st = (op == OP_ST); p.rd = rd_idx;
                    m_pend.push_back(p);
                    m_req = 1; m_mwe = p.is_st; m_addr = dr; m_wdata = st_data;
                end else begin
                    m_ret++;
                end
                if (op == OP_HLT) m_halted = 1;
            end

            @(negedge clk);
            chk($sformatf("r%0d_rf_we", c), 32'(rf_we), 32'(m_we));
            if (m_we) begin
                chk($sformatf("r%0d_rf_waddr", c), 32'(rf_waddr), 32'(m_wa));
                chk($sformatf("r%0d_rf_wdata", c), rf_wdata, m_wd);
            end
            chk($sformatf("r%0d_flags", c), {30'd0, flag_z, flag_s}, {30'd0, m_z, m_s});
            chk($sformatf("r%0d_mem_req", c), 32'(mem_req), 32'(m_req));
            if (m_req) begin
                chk($sformatf("r%0d_mem_we", c), 32'(mem_we), 32'(m_mwe));
                chk($sformatf("r%0d_mem_addr", c), mem_addr, m_addr);
                chk($sformatf("r%0d_mem_wdata", c), mem_wdata, m_wdata);
            end
            chk($sformatf("r%0d_halted", c), 32'(halted), 32'(m_halted));
            chk($sformatf("r%0d_retired", c), retired, m_ret);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
